// File: rtl/secded16_pkg.sv
// Shared constants, stage structs and the parity helper for the 16-bit
// extended-Hamming SEC-DED decoder.
package secded16_pkg;

    localparam int DATA_W = 11;
    localparam int PAR_W  = 5;

    // Parity bit indices within the 5-bit parity field
    localparam int P1   = 0;
    localparam int P2   = 1;
    localparam int P4   = 2;
    localparam int P8   = 3;
    localparam int PALL = 4;

    // Codeword position of each data bit; entry i is the position of d[i]
    localparam logic [DATA_W-1:0][3:0] DATA_POS = {
        4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5, 4'd3
    };

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [3:0]        s;
        logic              ov;
    } s1_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              corr;
        logic              uncorr;
        logic [PAR_W-1:0]  syndrome;
    } s2_t;

    // Parity an encoder would attach to d: p1/p2/p4/p8 plus the overall bit
    function automatic logic [PAR_W-1:0] calc_parity(input logic [DATA_W-1:0] d);
        logic [PAR_W-1:0] p;
        p = '0;
        for (int i = 0; i < DATA_W; i++)
            for (int k = 0; k < 4; k++)
                if (DATA_POS[i][k]) p[k] = p[k] ^ d[i];
        p[PALL] = (^d) ^ (^p[P8:P1]);
        return p;
    endfunction

endpackage

// File: rtl/secded16_syndrome.sv
// Combinational syndrome and overall-parity check for one received codeword.
module secded16_syndrome
    import secded16_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [PAR_W-1:0]  parity,
    output logic [3:0]        s,
    output logic              ov
);

    logic [PAR_W-1:0] calc;

    // Recompute parity; ov equals the XOR of all 16 received bits, folded
    // through the recomputed overall bit so every calc bit is used
    always_comb begin
        calc = calc_parity(data);
        s    = calc[P8:P1] ^ parity[P8:P1];
        ov   = calc[PALL] ^ parity[PALL] ^ (^s);
    end

endmodule

// File: rtl/dec_secded_16.sv
// Two-stage SEC-DED decoder with valid/ready backpressure and saturating
// corrected / uncorrectable counters.
module dec_secded_16
    import secded16_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PAR_W-1:0]  in_parity,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_corr,
    output logic              out_uncorr,
    output logic [PAR_W-1:0]  out_syndrome,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    localparam int STAGES = 2;

    logic [STAGES:1] vld_pipe;
    logic            s1_adv, s2_adv;
    logic [3:0]      syn_s;
    logic            syn_ov;
    s1_t             s1_d, s1_q;
    s2_t             s2_d, s2_q;

    secded16_syndrome u_syn (
        .data   (in_data),
        .parity (in_parity),
        .s      (syn_s),
        .ov     (syn_ov)
    );

    assign s2_adv   = !vld_pipe[2] || out_ready;
    assign s1_adv   = !vld_pipe[1] || s2_adv;
    assign in_ready = s1_adv;
    assign s1_d     = '{data: in_data, s: syn_s, ov: syn_ov};

    // Classify and correct; positions 1,2,4,8 and 0 match no data bit, so
    // parity-only errors leave the data untouched
    always_comb begin
        s2_d.data = s1_q.data;
        if (s1_q.ov)
            for (int i = 0; i < DATA_W; i++)
                if (s1_q.s == DATA_POS[i]) s2_d.data[i] = ~s1_q.data[i];
        s2_d.corr     = s1_q.ov;
        s2_d.uncorr   = !s1_q.ov && (s1_q.s != 4'd0);
        s2_d.syndrome = {s1_q.ov, s1_q.s};
    end

    // Pipeline registers; each stage holds while the stage after it stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
        end else begin
            if (s1_adv) begin
                vld_pipe[1] <= in_valid;
                s1_q        <= s1_d;
            end
            if (s2_adv) begin
                vld_pipe[2] <= vld_pipe[1];
                s2_q        <= s2_d;
            end
        end
    end

    assign out_valid    = vld_pipe[2];
    assign out_data     = s2_q.data;
    assign out_corr     = s2_q.corr;
    assign out_uncorr   = s2_q.uncorr;
    assign out_syndrome = s2_q.syndrome;

    // Saturating statistics counted on the output handshake; clear wins
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (out_valid && out_ready) begin
            if (out_corr && (corr_cnt != '1))
                corr_cnt <= corr_cnt + CNT_W'(1);
            if (out_uncorr && (uncorr_cnt != '1))
                uncorr_cnt <= uncorr_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dec_secded_16.sv
// Self-checking bench for dec_secded_16: directed steps followed by random
// traffic, scored against a position-based extended-Hamming model.
module tb_dec_secded_16;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, clr_cnt;
    logic [10:0] in_data;
    logic [4:0]  in_parity;

    logic        in_ready, out_valid, out_corr, out_uncorr;
    logic [10:0] out_data;
    logic [4:0]  out_syndrome;
    logic [15:0] corr_cnt, uncorr_cnt;

    logic        in_ready2, out_valid2, out_corr2, out_uncorr2;
    logic [10:0] out_data2;
    logic [4:0]  out_syndrome2;
    logic [1:0]  corr_cnt2, uncorr_cnt2;

    always #5 clk = ~clk;

    dec_secded_16 #(.CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_parity(in_parity), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_corr(out_corr),
        .out_uncorr(out_uncorr), .out_syndrome(out_syndrome), .clr_cnt(clr_cnt),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    dec_secded_16 #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_parity(in_parity), .out_valid(out_valid2),
        .out_ready(out_ready), .out_data(out_data2), .out_corr(out_corr2),
        .out_uncorr(out_uncorr2), .out_syndrome(out_syndrome2), .clr_cnt(clr_cnt),
        .corr_cnt(corr_cnt2), .uncorr_cnt(uncorr_cnt2)
    );

    typedef struct packed {
        logic [10:0] data;
        logic        corr;
        logic        uncorr;
        logic [4:0]  syn;
    } exp_t;

    exp_t q[$];
    int   total = 0, bad = 0;
    int   exp_c16 = 0, exp_u16 = 0, exp_c2 = 0, exp_u2 = 0;
    int   emitted = 0;
    logic last_in_hs, last_in_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_pow2(input int pos);
        return (pos & (pos - 1)) == 0;
    endfunction

    // Parity chosen so the XOR of the positions of all set bits is zero
    function automatic logic [4:0] encode(input logic [10:0] d);
        int s = 0, j = 0;
        logic [3:0] sv;
        for (int pos = 1; pos < 16; pos++)
            if (!is_pow2(pos)) begin
                if (d[j]) s ^= pos;
                j++;
            end
        sv = 4'(s);
        return {(^d) ^ (^sv), sv};
    endfunction

    // Lay out the codeword by position, locate the error as the XOR of the
    // positions of set bits, flip it, then read the data back out
    function automatic exp_t model(input logic [10:0] d, input logic [4:0] p);
        logic [15:0] cw;
        int j = 0, s = 0;
        logic ov;
        exp_t e;
        cw[0] = p[4];
        for (int pos = 1; pos < 16; pos++) begin
            if (pos == 1)      cw[pos] = p[0];
            else if (pos == 2) cw[pos] = p[1];
            else if (pos == 4) cw[pos] = p[2];
            else if (pos == 8) cw[pos] = p[3];
            else begin cw[pos] = d[j]; j++; end
        end
        for (int pos = 1; pos < 16; pos++)
            if (cw[pos]) s ^= pos;
        ov = ^cw;
        e.syn    = {ov, 4'(s)};
        e.corr   = ov;
        e.uncorr = !ov && (s != 0);
        if (ov && s != 0) cw[s] = ~cw[s];
        j = 0;
        for (int pos = 1; pos < 16; pos++)
            if (!is_pow2(pos)) begin e.data[j] = cw[pos]; j++; end
        return e;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v < mx) ? v + 1 : v;
    endfunction

    // One clock: check outputs against the model, account handshakes, advance
    task automatic tick();
        exp_t e;
        logic ih, oh;
        #1;
        last_in_ready = in_ready;
        if (!rst) begin
            chk("in_ready", in_ready, (q.size() < 2) || out_ready);
            chk("in_ready_w2", in_ready2, (q.size() < 2) || out_ready);
            if (out_valid) begin
                chk("out_valid_has_item", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q[0];
                    chk("out_data", out_data, e.data);
                    chk("out_corr", out_corr, e.corr);
                    chk("out_uncorr", out_uncorr, e.uncorr);
                    chk("out_syndrome", out_syndrome, e.syn);
                end
            end
            if (out_valid2 && q.size() > 0) chk("out_data_w2", out_data2, q[0].data);
            if (out_valid2) chk("out_flags_w2", {out_corr2, out_uncorr2, out_syndrome2},
                                {q[0].corr, q[0].uncorr, q[0].syn});
            chk("corr_cnt", corr_cnt, exp_c16);
            chk("uncorr_cnt", uncorr_cnt, exp_u16);
            chk("corr_cnt_w2", corr_cnt2, exp_c2);
            chk("uncorr_cnt_w2", uncorr_cnt2, exp_u2);
        end
        ih = in_valid && in_ready && !rst;
        oh = out_valid && out_ready && !rst;
        last_in_hs = ih;
        if (rst) begin
            q.delete();
            exp_c16 = 0; exp_u16 = 0; exp_c2 = 0; exp_u2 = 0;
        end else begin
            if (oh && q.size() > 0) begin
                e = q.pop_front();
                emitted++;
                if (e.corr)   begin exp_c16 = sat(exp_c16, 65535); exp_c2 = sat(exp_c2, 3); end
                if (e.uncorr) begin exp_u16 = sat(exp_u16, 65535); exp_u2 = sat(exp_u2, 3); end
            end
            if (clr_cnt) begin exp_c16 = 0; exp_u16 = 0; exp_c2 = 0; exp_u2 = 0; end
            if (ih) q.push_back(model(in_data, in_parity));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one word for a cycle, then idle one cycle so it reaches S2
    task automatic xfer(input logic [10:0] d, input logic [4:0] p);
        in_valid = 1'b1; in_data = d; in_parity = p;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic drain(input string tag);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) tick();
        chk(tag, q.size(), 0);
    endtask

    initial begin
        logic [15:0] v;
        int idx, base, b1, nerr;
        logic saw_stall;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_parity = '0;
        out_ready = 1'b1; clr_cnt = 1'b0;
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_syndrome", out_syndrome, 0);
        chk("rst_flags", {out_corr, out_uncorr}, 0);
        chk("rst_counters", {corr_cnt, uncorr_cnt}, 0);

        // Clean word and two-cycle latency
        xfer(11'h7FF, 5'h1F);
        chk("clean_valid", out_valid, 1);
        chk("clean_data", out_data, 11'h7FF);
        chk("clean_syn", out_syndrome, 5'h00);
        chk("clean_flags", {out_corr, out_uncorr}, 2'b00);
        tick();

        // Single data-bit error
        xfer(11'h001, 5'h00);
        chk("sec_syn", out_syndrome, 5'h13);
        chk("sec_data", out_data, 11'h000);
        chk("sec_corr", out_corr, 1);
        tick();
        chk("sec_cnt", corr_cnt, 1);

        // Parity-only errors
        xfer(11'h000, 5'h10);
        chk("pall_syn", out_syndrome, 5'h10);
        chk("pall_corr_data", {out_corr, out_data}, {1'b1, 11'h000});
        tick();
        xfer(11'h000, 5'h04);
        chk("p4_syn", out_syndrome, 5'h14);
        chk("p4_corr_data", {out_corr, out_data}, {1'b1, 11'h000});
        tick();

        // Double error
        xfer(11'h000, 5'h03);
        chk("ded_syn", out_syndrome, 5'h03);
        chk("ded_flags", {out_corr, out_uncorr}, 2'b01);
        chk("ded_data", out_data, 11'h000);
        tick();
        chk("ded_cnt", uncorr_cnt, 1);

        // Saturation of the 2-bit counter
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data = 11'($urandom);
            v = {encode(in_data), in_data};
            v[$urandom_range(15, 0)] ^= 1'b1;
            in_valid = 1'b1; in_data = v[10:0]; in_parity = v[15:11];
            tick();
        end
        drain("sat_drain");
        tick();
        chk("sat_cnt_w2", corr_cnt2, 3);
        chk("sat_cnt_w16", corr_cnt, 5);

        // Clear coinciding with a corrected handshake
        xfer(11'h001, 5'h00);
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        chk("clr_cnt_w2", corr_cnt2, 0);
        chk("clr_cnt_w16", corr_cnt, 0);

        // Backpressure: six clean words, out_ready low for cycles 3-5
        saw_stall = 1'b0; base = emitted; idx = 0;
        for (int c = 0; c < 40 && (idx < 6 || q.size() > 0); c++) begin
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (idx < 6);
            in_data   = 11'h100 + 11'(idx * 37);
            in_parity = encode(in_data);
            tick();
            if (!last_in_ready) saw_stall = 1'b1;
            if (last_in_hs) idx++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_stall_seen", saw_stall, 1);
        chk("bp_emitted", emitted - base, 6);
        chk("bp_drained", q.size(), 0);

        // Reset with two words in flight
        xfer(11'h001, 5'h00);
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 11'h0AA; in_parity = encode(11'h0AA); tick();
        in_data = 11'h055; in_parity = encode(11'h055); tick();
        in_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_cnt", {corr_cnt, uncorr_cnt}, 0);
        chk("midrst_cnt_w2", {corr_cnt2, uncorr_cnt2}, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_no_out", out_valid, 0);
        end

        // Random traffic with 0, 1 or 2 injected bit errors
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(3, 0) != 0);
            out_ready = ($urandom_range(3, 0) != 0);
            clr_cnt   = ($urandom_range(49, 0) == 0);
            in_data   = 11'($urandom);
            v = {encode(in_data), in_data};
            nerr = $urandom_range(2, 0);
            b1 = $urandom_range(15, 0);
            if (nerr >= 1) v[b1] ^= 1'b1;
            if (nerr == 2) v[(b1 + 1 + $urandom_range(14, 0)) % 16] ^= 1'b1;
            in_data = v[10:0]; in_parity = v[15:11];
            tick();
        end
        clr_cnt = 1'b0;
        drain("rand_drain");
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
